// File: rtl/keycode_fifo_pio.sv
// rtl/keycode_fifo_pio.sv - Avalon-MM keycode FIFO with stream drain, held out_port, status/flags and level irq; optional CPU peek/pop via KEYCODE_FIFO_PEEK_EN
module keycode_fifo_pio #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_port,
  output logic              irq
);
  localparam int CW = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] out_port_q, out_port_d;
  logic              ovf_q, ovf_d;
  logic              drn_q, drn_d;
  logic              irq_en_q, irq_en_d;
  logic              irq_q, irq_d;

  logic wr, wr_data, wr_ctrl;
  logic flush, clr_ovf, clr_drn;
  logic stream_pop, pop;
  logic full, empty;
  logic push_ok, ovf_set, drn_set;
  logic unused_wdata;

  // Bus decode: one register access per cycle, so a push never meets a CONTROL write.
  assign wr      = chipselect & ~write_n;
  assign wr_data = wr & (address == 2'd0);
  assign wr_ctrl = wr & (address == 2'd2);
  assign flush   = wr_ctrl & writedata[1];
  assign clr_ovf = wr_ctrl & writedata[2];
  assign clr_drn = wr_ctrl & writedata[3];

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign out_valid = ~empty;
  assign out_data  = mem_q[rd_ptr_q];
  assign out_port  = out_port_q;
  assign irq       = irq_q;

  assign stream_pop = out_valid & out_ready;

`ifdef KEYCODE_FIFO_PEEK_EN
  logic cpu_pop;
  // CPU pop via addr3 merges with a stream pop so at most one entry leaves per cycle.
  assign cpu_pop = wr & (address == 2'd3) & writedata[0] & out_valid;
  assign pop     = (stream_pop | cpu_pop) & ~flush;
`else
  assign pop = stream_pop & ~flush;
`endif

  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_ok = wr_data & (~full | pop);
  assign ovf_set = wr_data & full & ~pop;
  assign drn_set = pop & (count_q == CW'(1)) & ~push_ok;

  assign unused_wdata = ^writedata[31:DATA_W];

  // Next-state for pointers, count, held output and flags; flush beats a same-cycle pop.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    out_port_d = out_port_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        out_port_d = out_data;
      end
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (push_ok && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push_ok) begin
        count_d = count_q - CW'(1);
      end
    end
    ovf_d    = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    drn_d    = drn_set ? 1'b1 : (clr_drn ? 1'b0 : drn_q);
    irq_en_d = wr_ctrl ? writedata[0] : irq_en_q;
    irq_d    = irq_en_q & (ovf_q | drn_q);
  end

  // Control state; reset discards every queued entry at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      out_port_q <= '0;
      ovf_q      <= 1'b0;
      drn_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      out_port_q <= out_port_d;
      ovf_q      <= ovf_d;
      drn_q      <= drn_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
    end
  end

  // Entry storage; validity comes only from the pointers and count, so no reset here.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= writedata[DATA_W-1:0];
    end
  end

  // Zero-wait-state register read mux; reads never change state.
  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata = 32'(out_port_q);
      2'd1: readdata = {16'd0, 8'(count_q), 4'd0, drn_q, ovf_q, full, empty};
      2'd2: readdata = {31'd0, irq_en_q};
`ifdef KEYCODE_FIFO_PEEK_EN
      2'd3: readdata = empty ? 32'd0 : 32'(out_data);
`else
      2'd3: readdata = 32'd0;
`endif
      default: readdata = '0;
    endcase
  end

endmodule
